// File: rtl/decode_stage_pipe_pkg.sv
// Shared decode definitions for the ID stage: opcodes, control encoding,
// ID_EX layout constants and source/destination usage per opcode.
package decode_stage_pipe_pkg;

  typedef enum logic [5:0] {
    OP_ADD = 6'd0,  OP_SUB = 6'd1,  OP_LI  = 6'd2,  OP_SHL = 6'd3,
    OP_SHR = 6'd4,  OP_AND = 6'd5,  OP_OR  = 6'd6,  OP_XOR = 6'd7,
    OP_BR  = 6'd8,  OP_BNE = 6'd9,  OP_MOV = 6'd10, OP_ADI = 6'd11,
    OP_MUL = 6'd12, OP_HLT = 6'd13, OP_NOP = 6'd14
  } opcode_e;

  // Control bit index equals the opcode value; opcodes from here up are illegal.
  localparam logic [5:0] OP_FIRST_ILLEGAL = 6'd15;
  localparam int unsigned CTRL_MIN_W = 15;

  localparam int unsigned INSTR_W   = 32;
  localparam int unsigned INSTR_LSB = 0;
  localparam int unsigned PC_LSB    = INSTR_W;

  typedef enum logic [1:0] {
    DEST_NONE,
    DEST_RD,
    DEST_RT
  } dest_sel_e;

  function automatic logic uses_rs(input logic [5:0] op);
    case (opcode_e'(op))
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MUL, OP_BNE,
      OP_SHL, OP_SHR, OP_MOV, OP_ADI: uses_rs = 1'b1;
      default:                        uses_rs = 1'b0;
    endcase
  endfunction

  function automatic logic uses_rt(input logic [5:0] op);
    case (opcode_e'(op))
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MUL, OP_BNE: uses_rt = 1'b1;
      default:                                              uses_rt = 1'b0;
    endcase
  endfunction

  function automatic dest_sel_e dest_sel(input logic [5:0] op);
    case (opcode_e'(op))
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MUL: dest_sel = DEST_RD;
      OP_LI, OP_SHL, OP_SHR, OP_MOV, OP_ADI:          dest_sel = DEST_RT;
      default:                                        dest_sel = DEST_NONE;
    endcase
  endfunction

endpackage

// File: rtl/decode_stage_pipe_if.sv
// Fetch-side, write-back and execute-side signals of the decode stage.
interface decode_stage_pipe_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREG   = 32,
  parameter int unsigned PC_W   = 32,
  parameter int unsigned CTRL_W = 16
);
  localparam int unsigned AW      = $clog2(NREG);
  localparam int unsigned ID_EX_W = 32 + PC_W + 3 * XLEN + CTRL_W;

  logic               if_valid;
  logic               if_ready;
  logic [PC_W+31:0]   if_id;
  logic               wb_en;
  logic [AW-1:0]      wb_addr;
  logic [XLEN-1:0]    wb_data;
  logic               ex_valid;
  logic               ex_ready;
  logic [ID_EX_W-1:0] id_ex;
  logic               halted;
  logic               illegal;

  modport master (
    output if_valid, if_id, wb_en, wb_addr, wb_data, ex_ready,
    input  if_ready, ex_valid, id_ex, halted, illegal
  );

  modport slave (
    input  if_valid, if_id, wb_en, wb_addr, wb_data, ex_ready,
    output if_ready, ex_valid, id_ex, halted, illegal
  );
endinterface

// File: rtl/decode_stage_pipe_regfile_2r1w.sv
// NREG x XLEN register file: two async read ports, one write port,
// r0 hard-wired to zero, same-cycle write data bypassed to the readers.
module regfile_2r1w #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32,
  parameter int unsigned AW   = $clog2(NREG)
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   raddr_a,
  output logic [XLEN-1:0] rdata_a,
  input  logic [AW-1:0]   raddr_b,
  output logic [XLEN-1:0] rdata_b
);
  logic [XLEN-1:0] mem [NREG];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (we && waddr != '0) begin
      mem[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata_a = mem[raddr_a];
    if (raddr_a == '0)             rdata_a = '0;
    else if (we && waddr == raddr_a) rdata_a = wdata;
  end

  always_comb begin
    rdata_b = mem[raddr_b];
    if (raddr_b == '0)             rdata_b = '0;
    else if (we && waddr == raddr_b) rdata_b = wdata;
  end
endmodule

// File: rtl/decode_stage_pipe.sv
// Instruction-decode stage: IF_ID in, packed ID_EX out, with RAW scoreboard
// stalls, write-back into the register file, sticky HLT and illegal flags.
module decode_stage_pipe
  import decode_stage_pipe_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREG   = 32,
  parameter int unsigned PC_W   = 32,
  parameter int unsigned CTRL_W = 16
) (
  input logic              clock,
  input logic              reset_n,
  decode_stage_pipe_if.slave bus
);
  localparam int unsigned AW      = $clog2(NREG);
  localparam int unsigned ID_EX_W = INSTR_W + PC_W + 3 * XLEN + CTRL_W;

  logic [31:0]        instr;
  logic [PC_W-1:0]    pc;
  logic [5:0]         op;
  logic [AW-1:0]      rs_a, rt_a, rd_a, dest_a;
  logic [XLEN-1:0]    rs_val, rt_val, imm;
  logic [CTRL_W-1:0]  ctrl;
  logic [NREG-1:0]    busy, busy_next;
  logic               rs_block, rt_block, hazard, ready, accept;
  logic               ex_valid_q, halted_q, illegal_q;
  logic [ID_EX_W-1:0] id_ex_q;

  assign instr = bus.if_id[31:0];
  assign pc    = bus.if_id[PC_W+31:PC_LSB];
  assign op    = instr[31:26];
  assign rs_a  = instr[21 +: AW];
  assign rt_a  = instr[16 +: AW];
  assign rd_a  = instr[11 +: AW];
  assign imm   = {{(XLEN-16){instr[15]}}, instr[15:0]};

  regfile_2r1w #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) u_regfile (
    .clock   (clock),
    .reset_n (reset_n),
    .we      (bus.wb_en),
    .waddr   (bus.wb_addr),
    .wdata   (bus.wb_data),
    .raddr_a (rs_a),
    .rdata_a (rs_val),
    .raddr_b (rt_a),
    .rdata_b (rt_val)
  );

  // No-destination maps onto r0, which the scoreboard never marks busy.
  always_comb begin
    dest_a = '0;
    case (dest_sel(op))
      DEST_RD: dest_a = rd_a;
      DEST_RT: dest_a = rt_a;
      default: dest_a = '0;
    endcase
  end

  always_comb begin
    ctrl = '0;
    if (op < OP_FIRST_ILLEGAL) ctrl[op[3:0]] = 1'b1;
  end

  assign rs_block = uses_rs(op) && busy[rs_a] && !(bus.wb_en && bus.wb_addr == rs_a);
  assign rt_block = uses_rt(op) && busy[rt_a] && !(bus.wb_en && bus.wb_addr == rt_a);
  assign hazard   = rs_block || rt_block;
  assign ready    = !halted_q && !hazard && (!ex_valid_q || bus.ex_ready);
  assign accept   = bus.if_valid && ready;

  // Set is applied after clear so a same-cycle issue to the written reg stays busy.
  always_comb begin
    busy_next = busy;
    if (bus.wb_en) busy_next[bus.wb_addr] = 1'b0;
    if (accept)    busy_next[dest_a]      = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) busy <= '0;
    else          busy <= busy_next;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ex_valid_q <= 1'b0;
      id_ex_q    <= '0;
      halted_q   <= 1'b0;
      illegal_q  <= 1'b0;
    end else if (accept) begin
      ex_valid_q <= 1'b1;
      id_ex_q    <= {ctrl, imm, rt_val, rs_val, pc, instr};
      if (op == OP_HLT)          halted_q  <= 1'b1;
      if (op >= OP_FIRST_ILLEGAL) illegal_q <= 1'b1;
    end else if (bus.ex_ready) begin
      ex_valid_q <= 1'b0;
    end
  end

  assign bus.if_ready = ready;
  assign bus.ex_valid = ex_valid_q;
  assign bus.id_ex    = id_ex_q;
  assign bus.halted   = halted_q;
  assign bus.illegal  = illegal_q;
endmodule

// File: tb/tb_decode_stage_pipe.sv
// Directed bench for decode_stage_pipe: handshake, hazards, write-through,
// stall hold, r0 handling, async reset, illegal and HLT.
module tb_decode_stage_pipe;
  localparam int unsigned XLEN = 32, NREG = 32, PC_W = 32, CTRL_W = 16;
  localparam int unsigned W = 32 + PC_W + 3 * XLEN + CTRL_W;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   tests = 0;
  int   failed = 0;

  always #5 clock = ~clock;

  decode_stage_pipe_if #(.XLEN(XLEN), .NREG(NREG), .PC_W(PC_W), .CTRL_W(CTRL_W)) bus ();

  decode_stage_pipe #(.XLEN(XLEN), .NREG(NREG), .PC_W(PC_W), .CTRL_W(CTRL_W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  function automatic logic [31:0] rtype(input logic [5:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [4:0] rt);
    return {op, rs, rt, rd, 11'd0};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] im);
    return {op, rs, rt, im};
  endfunction

  // Reference packing of ID_EX from the instruction and the expected operands.
  function automatic logic [W-1:0] mk(input logic [31:0] pc, input logic [31:0] ins,
                                      input logic [31:0] rs_v, input logic [31:0] rt_v);
    logic [15:0] c;
    logic [31:0] im;
    c  = (ins[31:26] < 6'd15) ? (16'd1 << ins[31:26]) : 16'd0;
    im = {{16{ins[15]}}, ins[15:0]};
    return {c, im, rt_v, rs_v, pc, ins};
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic edge1();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins);
    bus.if_valid = v;
    bus.if_id    = {pc, ins};
  endtask

  task automatic wb(input logic en, input logic [4:0] a, input logic [31:0] d);
    bus.wb_en   = en;
    bus.wb_addr = a;
    bus.wb_data = d;
  endtask

  logic [31:0] i_add1, i_li, i_add2, i_nop, i_mov0, i_shl, i_add3, i_mov1, i_ill, i_hlt;

  initial begin
    i_add1 = rtype(6'd0, 5'd3, 5'd1, 5'd2);
    i_li   = itype(6'd2, 5'd0, 5'd4, 16'h8001);
    i_add2 = rtype(6'd0, 5'd5, 5'd4, 5'd0);
    i_nop  = itype(6'd14, 5'd0, 5'd0, 16'h0);
    i_mov0 = itype(6'd10, 5'd1, 5'd0, 16'h0);
    i_shl  = itype(6'd3, 5'd0, 5'd8, 16'h0);
    i_add3 = rtype(6'd0, 5'd9, 5'd8, 5'd0);
    i_mov1 = itype(6'd10, 5'd1, 5'd0, 16'h0);
    i_ill  = itype(6'h3F, 5'd1, 5'd2, 16'h0);
    i_hlt  = itype(6'd13, 5'd0, 5'd0, 16'h0);

    drive(1'b0, 32'h0, 32'h0);
    wb(1'b0, 5'd0, 32'h0);
    bus.ex_ready = 1'b1;
    reset_n = 1'b0;
    edge1(); edge1();
    chk("rst_ex_valid", W'(bus.ex_valid), W'(1'b0));
    chk("rst_id_ex", bus.id_ex, '0);
    chk("rst_flags", W'({bus.halted, bus.illegal}), W'(2'b00));
    #1 reset_n = 1'b1;
    #1 chk("rst_if_ready", W'(bus.if_ready), W'(1'b1));

    // 1: write r1, r2 then ADD r3 = r1 + r2
    edge1(); wb(1'b1, 5'd1, 32'hFFFF_FFFF);
    edge1(); wb(1'b1, 5'd2, 32'hAAAA_AAAA);
    edge1(); wb(1'b0, 5'd0, 32'h0); drive(1'b1, 32'h100, i_add1);
    #1 chk("add_if_ready", W'(bus.if_ready), W'(1'b1));
    edge1();
    chk("add_ex_valid", W'(bus.ex_valid), W'(1'b1));
    chk("add_id_ex", bus.id_ex, mk(32'h100, i_add1, 32'hFFFF_FFFF, 32'hAAAA_AAAA));

    // 2: LI r4 then dependent ADD stalls until write-back of r4
    drive(1'b1, 32'h104, i_li);
    edge1();
    chk("li_id_ex", bus.id_ex, mk(32'h104, i_li, 32'h0, 32'h0));
    chk("li_imm_sext", W'(bus.id_ex[159:128]), W'(32'hFFFF_8001));
    drive(1'b1, 32'h108, i_add2);
    #1 chk("raw_stall_0", W'(bus.if_ready), W'(1'b0));
    edge1();
    chk("raw_drain_ex_valid", W'(bus.ex_valid), W'(1'b0));
    chk("raw_stall_1", W'(bus.if_ready), W'(1'b0));
    edge1();
    chk("raw_stall_2", W'(bus.if_ready), W'(1'b0));
    wb(1'b1, 5'd4, 32'h1357_9BDF);
    #1 chk("raw_release", W'(bus.if_ready), W'(1'b1));
    edge1();
    chk("raw_bypass_id_ex", bus.id_ex, mk(32'h108, i_add2, 32'h1357_9BDF, 32'h0));

    // 3: execute back-pressure holds id_ex for 3 cycles
    wb(1'b0, 5'd0, 32'h0);
    bus.ex_ready = 1'b0;
    drive(1'b1, 32'h10C, i_nop);
    for (int unsigned k = 0; k < 3; k++) begin
      #1 chk("bp_if_ready", W'(bus.if_ready), W'(1'b0));
      edge1();
      chk("bp_hold_id_ex", bus.id_ex, mk(32'h108, i_add2, 32'h1357_9BDF, 32'h0));
      chk("bp_hold_valid", W'(bus.ex_valid), W'(1'b1));
    end
    bus.ex_ready = 1'b1;
    #1 chk("bp_release_ready", W'(bus.if_ready), W'(1'b1));
    edge1();
    chk("bp_next_issue", bus.id_ex, mk(32'h10C, i_nop, 32'h0, 32'h0));

    // 5: r0 write ignored, r0 dest never busy
    drive(1'b0, 32'h10C, i_nop); wb(1'b1, 5'd0, 32'h1234_5678);
    edge1(); wb(1'b0, 5'd0, 32'h0); drive(1'b1, 32'h110, i_mov0);
    edge1();
    chk("mov_r0_id_ex", bus.id_ex, mk(32'h110, i_mov0, 32'hFFFF_FFFF, 32'h0));
    drive(1'b1, 32'h114, i_shl);
    #1 chk("r0_no_stall", W'(bus.if_ready), W'(1'b1));
    edge1();
    chk("r0_reads_zero", bus.id_ex, mk(32'h114, i_shl, 32'h0, 32'h0));

    // 6: async reset while stalled on r8 with a valid output held
    drive(1'b1, 32'h118, i_add3);
    #1 chk("pre_rst_stall", W'(bus.if_ready), W'(1'b0));
    #1 reset_n = 1'b0; bus.if_valid = 1'b0;
    #1 chk("mid_rst_ex_valid", W'(bus.ex_valid), W'(1'b0));
    chk("mid_rst_id_ex", bus.id_ex, '0);
    edge1(); #1 reset_n = 1'b1;
    #1 chk("post_rst_busy_clear", W'(bus.if_ready), W'(1'b1));
    drive(1'b1, 32'h200, i_mov1);
    edge1();
    chk("post_rst_regs_zero", bus.id_ex, mk(32'h200, i_mov1, 32'h0, 32'h0));

    // 4: illegal opcode then HLT
    drive(1'b1, 32'h300, i_ill);
    edge1();
    chk("ill_id_ex", bus.id_ex, mk(32'h300, i_ill, 32'h0, 32'h0));
    chk("ill_flag", W'(bus.illegal), W'(1'b1));
    drive(1'b1, 32'h304, i_hlt);
    edge1();
    chk("hlt_ctrl", W'(bus.id_ex[175:160]), W'(16'h2000));
    chk("hlt_flags", W'({bus.halted, bus.illegal}), W'(2'b11));
    drive(1'b1, 32'h308, i_nop);
    for (int unsigned k = 0; k < 20; k++) begin
      chk("hlt_if_ready", W'(bus.if_ready), W'(1'b0));
      edge1();
    end
    chk("hlt_sticky", W'({bus.halted, bus.illegal}), W'(2'b11));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
